booth_multiplier_seq: RTL and testbench

//  Sequential radix-2 Booth multiplier with start/ready handshake and runtime signed/unsigned select.

---
 rtl/booth_pkg.sv | 21 ++
 rtl/booth_multiplier_seq_if.sv | 21 ++
 rtl/booth_step.sv | 34 +++
 rtl/booth_multiplier_seq.sv | 119 +++++++++++
 tb/tb_booth_multiplier_seq.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types, widths and Booth code constants for booth_multiplier_seq
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Extended operand width: one guard bit so unsigned operands become non-negative signed values
    function automatic int booth_w1(input int mul_width);
        return mul_width + 1;
    endfunction

    function automatic int booth_cnt_w(input int mul_width);
        return $clog2(mul_width + 2);
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_if.sv
// rtl/booth_multiplier_seq_if.sv - start/ready request and result bundle for booth_multiplier_seq
interface booth_multiplier_seq_if #(
    parameter int MUL_WIDTH = 4
);
    logic                   start;
    logic                   sign;
    logic [MUL_WIDTH-1:0]   data_in1;
    logic [MUL_WIDTH-1:0]   data_in2;
    logic [2*MUL_WIDTH-1:0] data_out;
    logic                   ready;

    modport master (
        output start, sign, data_in1, data_in2,
        input  data_out, ready
    );

    modport slave (
        input  start, sign, data_in1, data_in2,
        output data_out, ready
    );
endinterface

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth step: add/sub of M, then arithmetic shift of {A,Q,q_1}
module booth_step
    import booth_pkg::*;
#(
    parameter int W1 = 5
) (
    input  logic [W1-1:0] a_i,
    input  logic [W1-1:0] q_i,
    input  logic          q1_i,
    input  logic [W1-1:0] m_i,
    output logic [W1-1:0] a_o,
    output logic [W1-1:0] q_o,
    output logic          q1_o
);
    logic [W1:0] a_x;
    logic [W1:0] m_x;
    logic [W1:0] sum;

    // One extra bit keeps A +/- M exact; the shifted result always fits back into W1 bits
    always_comb begin
        a_x = {a_i[W1-1], a_i};
        m_x = {m_i[W1-1], m_i};
        case ({q_i[0], q1_i})
            BOOTH_ADD: sum = a_x + m_x;
            BOOTH_SUB: sum = a_x - m_x;
            default:   sum = a_x;
        endcase
    end

    assign a_o  = sum[W1:1];
    assign q_o  = {sum[0], q_i[W1-1:1]};
    assign q1_o = q_i[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// rtl/booth_multiplier_seq.sv - sequential radix-2 Booth multiplier, one step per clock, signed/unsigned select
// Optional feature macro: BOOTH_ZERO_SKIP_EN (a zero operand completes in one edge).
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int MUL_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    booth_multiplier_seq_if.slave bus
);
    localparam int W1 = booth_w1(MUL_WIDTH);
    localparam int CW = booth_cnt_w(MUL_WIDTH);

    state_t                 state_q, state_d;
    logic [W1-1:0]          a_q, a_d;
    logic [W1-1:0]          q_q, q_d;
    logic                   q1_q, q1_d;
    logic [W1-1:0]          m_q, m_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2*MUL_WIDTH-1:0] prod_q, prod_d;

    logic [W1-1:0]   step_a;
    logic [W1-1:0]   step_q;
    logic            step_q1;
    logic [2*W1-1:0] full_prod;
    logic            capture;
    logic            last_step;
    logic            zero_skip;

    booth_step #(.W1(W1)) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (step_a),
        .q_o  (step_q),
        .q1_o (step_q1)
    );

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_skip = (bus.data_in1 == '0) || (bus.data_in2 == '0);
`else
    assign zero_skip = 1'b0;
`endif

    assign capture   = (state_q == IDLE) && bus.start;
    assign last_step = (state_q == CALC) && (cnt_q == CW'(1));
    assign full_prod = {step_a, step_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready    = (state_q == IDLE);
        bus.data_out = prod_q;
    end

    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        q1_d   = q1_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (capture) begin
            a_d   = '0;
            q1_d  = 1'b0;
            m_d   = bus.sign ? {bus.data_in1[MUL_WIDTH-1], bus.data_in1} : {1'b0, bus.data_in1};
            q_d   = bus.sign ? {bus.data_in2[MUL_WIDTH-1], bus.data_in2} : {1'b0, bus.data_in2};
            cnt_d = CW'(W1);
            // A single step on all-zero operands yields a zero product on the next edge
            if (zero_skip) begin
                m_d   = '0;
                q_d   = '0;
                cnt_d = CW'(1);
            end
        end else if (state_q == CALC) begin
            a_d   = step_a;
            q_d   = step_q;
            q1_d  = step_q1;
            cnt_d = cnt_q - CW'(1);
            if (last_step) prod_d = full_prod[2*MUL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            q_q    <= '0;
            q1_q   <= 1'b0;
            m_q    <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            q1_q   <= q1_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// tb/tb_booth_multiplier_seq.sv - directed vectors, handshake corner cases and exhaustive sweep for booth_multiplier_seq
module tb_booth_multiplier_seq;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    booth_multiplier_seq_if #(.MUL_WIDTH(4)) bif ();

    booth_multiplier_seq #(.MUL_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sign;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Waits for ready after the current edge; n counts edges waited
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (bif.ready) break;
        end
        if (!bif.ready) check("timeout_ready", 32'(bif.ready), 32'd1);
    endtask

    task automatic run_op(input logic s, input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] prod, output int lat);
        bif.sign     = s;
        bif.data_in1 = a;
        bif.data_in2 = b;
        bif.start    = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        wait_done(lat);
        prod = bif.data_out;
    endtask

    function automatic int exp_latency(input logic [3:0] a, input logic [3:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
        return (a == 4'd0 || b == 4'd0) ? 1 : 5;
`else
        return (a == b && a == 4'hx) ? 0 : 5;
`endif
    endfunction

    initial begin
        logic [7:0] prod;
        int         lat;
        int         n;
        int         ra;
        int         rb;
        logic [7:0] ref_p;

        checks   = 0;
        failures = 0;
        vecs[0] = '{1'b1, 4'h9, 4'hE, 8'h0E};
        vecs[1] = '{1'b0, 4'hF, 4'hF, 8'hE1};
        vecs[2] = '{1'b1, 4'hF, 4'hF, 8'h01};
        vecs[3] = '{1'b1, 4'h8, 4'h8, 8'h40};
        vecs[4] = '{1'b1, 4'h7, 4'h8, 8'hC8};
        vecs[5] = '{1'b0, 4'h0, 4'h5, 8'h00};
        vecs[6] = '{1'b1, 4'h3, 4'hB, 8'hF1};
        vecs[7] = '{1'b0, 4'hA, 4'h3, 8'h1E};

        rst = 1'b1;
        bif.start = 1'b0;
        bif.sign = 1'b0;
        bif.data_in1 = 4'h0;
        bif.data_in2 = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(bif.ready), 32'd1);
        check("reset_data_out", 32'(bif.data_out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].sign, vecs[i].a, vecs[i].b, prod, lat);
            check($sformatf("vec%0d_prod", i), 32'(prod), 32'(vecs[i].prod));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_latency(vecs[i].a, vecs[i].b)));
        end

        // Restart attempt mid-CALC is ignored; previous product holds during CALC
        bif.sign = 1'b1; bif.data_in1 = 4'h9; bif.data_in2 = 4'hE; bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        check("busy_after_capture", 32'(bif.ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        bif.sign = 1'b0; bif.data_in1 = 4'h5; bif.data_in2 = 4'h5; bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        check("hold_prev_product", 32'(bif.data_out), 32'h1E);
        wait_done(n);
        check("restart_latency", 32'(3 + n), 32'd5);
        check("restart_prod", 32'(bif.data_out), 32'h0E);

        // Start held high: new capture on the first edge ready is seen
        bif.sign = 1'b0; bif.data_in1 = 4'h2; bif.data_in2 = 4'h3; bif.start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n);
        check("held_first_latency", 32'(n), 32'd5);
        check("held_first_prod", 32'(bif.data_out), 32'h06);
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        check("held_recapture_busy", 32'(bif.ready), 32'd0);
        wait_done(n);
        check("held_second_prod", 32'(bif.data_out), 32'h06);

        // Asynchronous reset mid-CALC
        bif.sign = 1'b0; bif.data_in1 = 4'h7; bif.data_in2 = 4'h7; bif.start = 1'b1;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bif.ready), 32'd1);
        check("abort_data_out", 32'(bif.data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 4'h7, 4'h7, prod, lat);
        check("post_abort_prod", 32'(prod), 32'd49);
        check("post_abort_latency", 32'(lat), 32'd5);

        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    ra = (s == 1 && a > 7) ? a - 16 : a;
                    rb = (s == 1 && b > 7) ? b - 16 : b;
                    ref_p = 8'(ra * rb);
                    run_op(s[0], 4'(a), 4'(b), prod, lat);
                    check($sformatf("sweep_s%0d_%0d_%0d", s, a, b), 32'(prod), 32'(ref_p));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
